ans_encoder: RTL and testbench



---
 rtl/ans_encoder_pkg.sv | 27 ++
 rtl/ans_encoder_if.sv | 31 +++
 rtl/ans_encoder_divider.sv | 63 ++++++
 rtl/ans_encoder.sv | 185 ++++++++++++++++++
 tb/tb_ans_encoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ans_encoder_pkg.sv
// Shared definitions for the rANS encoder: default widths, frequency-table
// query codes (common with ans_decoder) and the encoder state encoding.
package ans_encoder_pkg;

  localparam int DEF_SYM_WIDTH   = 4;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_STATE_WIDTH = 16;
  localparam int DEF_SYM_COUNT   = 16;

  localparam logic [1:0] READ_TYPE_NONE = 2'd0;
  localparam logic [1:0] READ_TYPE_CMF  = 2'd1;
  localparam logic [1:0] READ_TYPE_PMF  = 2'd2;
  localparam logic [1:0] READ_TYPE_ICMF = 2'd3;

  typedef enum logic [3:0] {
    ENC_INIT,
    ENC_IDLE,
    ENC_FETCH_PMF,
    ENC_FETCH_CDF,
    ENC_RENORM,
    ENC_DIVIDE,
    ENC_UPDATE,
    ENC_FLUSH,
    ENC_DONE
  } enc_state_t;

endpackage

// File: rtl/ans_encoder_if.sv
// Symbol/nibble streams and frequency-table port of the rANS encoder.
// master is the encoder side, slave is the host/table side.
interface ans_encoder_if import ans_encoder_pkg::*; #(
  parameter int SYM_WIDTH = DEF_SYM_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic [SYM_WIDTH-1:0]           in;
  logic                           in_last;
  logic                           in_vld;
  logic                           in_rdy;
  logic [SYM_WIDTH-1:0]           out;
  logic                           out_vld;
  logic                           out_rdy;
  logic [1:0]                     read_type;
  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query;
  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result;
  logic                           read_rdy;
  logic                           done;

  modport master (
    input  in, in_last, in_vld, out_rdy, read_result, read_rdy,
    output in_rdy, out, out_vld, read_type, read_query, done
  );

  modport slave (
    output in, in_last, in_vld, out_rdy, read_result, read_rdy,
    input  in_rdy, out, out_vld, read_type, read_query, done
  );

endinterface

// File: rtl/ans_encoder_divider.sv
// Restoring divider producing one quotient bit per cycle; a start accepted
// while idle yields a one-cycle done pulse WIDTH cycles later.
module ans_seq_divider import ans_encoder_pkg::*; #(
  parameter int WIDTH = DEF_STATE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // quo doubles as the dividend shift register; a borrow in diff means "keep"
  assign shifted   = {rem, quo[WIDTH-1]};
  assign diff      = shifted - {1'b0, div};
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      div  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          quo  <= dividend;
          rem  <= '0;
          div  <= divisor;
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else begin
        rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ans_encoder.sv
// rANS encoder: emits renormalisation nibbles per symbol and a final
// most-significant-first state flush; the stream is consumed in reverse.
module ans_encoder import ans_encoder_pkg::*; #(
  parameter int SYM_WIDTH   = DEF_SYM_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int STATE_WIDTH = DEF_STATE_WIDTH,
  parameter int SYM_COUNT   = DEF_SYM_COUNT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  ans_encoder_if.master bus
);

  localparam int RW      = CNT_WIDTH + SYM_WIDTH;
  localparam int NIBBLES = STATE_WIDTH / SYM_WIDTH;
  localparam int NCW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  enc_state_t             state;
  logic [STATE_WIDTH-1:0] x, m, f, c, q, r;
  logic [SYM_WIDTH-1:0]   sym;
  logic                   last;
  logic                   pending;
  logic                   div_start;
  logic [NCW-1:0]         nib_cnt;

  logic [STATE_WIDTH-1:0] div_quo, div_rem;
  logic                   div_done;
  logic [STATE_WIDTH-1:0] result_ext;
  logic                   need_renorm;
  logic [STATE_WIDTH-1:0] x_update;

  assign result_ext  = STATE_WIDTH'(bus.read_result);
  assign need_renorm = {{SYM_WIDTH{1'b0}}, x} >= {f, {SYM_WIDTH{1'b0}}};
  // Only the low STATE_WIDTH bits of the double-width product survive, and
  // modular arithmetic gives those bits directly at STATE_WIDTH.
  assign x_update    = q * m + c + r;

  ans_seq_divider #(.WIDTH(STATE_WIDTH)) divider (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .start    (div_start),
    .dividend (x),
    .divisor  (f),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done)
  );

  // Every table query and divider run is a two-phase step tracked by
  // pending: issue first, then wait for the answer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ENC_INIT;
      x              <= '0;
      m              <= '0;
      f              <= '0;
      c              <= '0;
      q              <= '0;
      r              <= '0;
      sym            <= '0;
      last           <= 1'b0;
      pending        <= 1'b0;
      div_start      <= 1'b0;
      nib_cnt        <= '0;
      bus.in_rdy     <= 1'b0;
      bus.out        <= '0;
      bus.out_vld    <= 1'b0;
      bus.done       <= 1'b0;
      bus.read_type  <= READ_TYPE_NONE;
      bus.read_query <= '0;
    end else if (ena) begin
      case (state)
        ENC_INIT: begin
          if (!pending) begin
            bus.read_type  <= READ_TYPE_CMF;
            bus.read_query <= RW'(SYM_COUNT - 1);
            pending        <= 1'b1;
          end else if (bus.read_rdy) begin
            bus.read_type <= READ_TYPE_NONE;
            pending       <= 1'b0;
            m             <= result_ext;
            x             <= result_ext;
            bus.in_rdy    <= 1'b1;
            state         <= ENC_IDLE;
          end
        end
        ENC_IDLE: begin
          if (bus.in_vld && bus.in_rdy) begin
            sym        <= bus.in;
            last       <= bus.in_last;
            bus.in_rdy <= 1'b0;
            state      <= ENC_FETCH_PMF;
          end
        end
        ENC_FETCH_PMF: begin
          if (!pending) begin
            bus.read_type  <= READ_TYPE_PMF;
            bus.read_query <= RW'(sym);
            pending        <= 1'b1;
          end else if (bus.read_rdy) begin
            bus.read_type <= READ_TYPE_NONE;
            pending       <= 1'b0;
            f             <= result_ext;
            state         <= ENC_FETCH_CDF;
          end
        end
        ENC_FETCH_CDF: begin
          if (sym == '0) begin
            c     <= '0;
            state <= ENC_RENORM;
          end else if (!pending) begin
            bus.read_type  <= READ_TYPE_CMF;
            bus.read_query <= RW'(sym) - RW'(1);
            pending        <= 1'b1;
          end else if (bus.read_rdy) begin
            bus.read_type <= READ_TYPE_NONE;
            pending       <= 1'b0;
            c             <= result_ext;
            state         <= ENC_RENORM;
          end
        end
        ENC_RENORM: begin
          if (bus.out_vld) begin
            if (bus.out_rdy) begin
              bus.out_vld <= 1'b0;
              x           <= x >> SYM_WIDTH;
            end
          end else if (need_renorm) begin
            bus.out     <= x[SYM_WIDTH-1:0];
            bus.out_vld <= 1'b1;
          end else begin
            state <= ENC_DIVIDE;
          end
        end
        ENC_DIVIDE: begin
          if (!pending) begin
            div_start <= 1'b1;
            pending   <= 1'b1;
          end else begin
            div_start <= 1'b0;
            if (div_done) begin
              q       <= div_quo;
              r       <= div_rem;
              pending <= 1'b0;
              state   <= ENC_UPDATE;
            end
          end
        end
        ENC_UPDATE: begin
          x <= x_update;
          if (last) begin
            nib_cnt <= '0;
            state   <= ENC_FLUSH;
          end else begin
            bus.in_rdy <= 1'b1;
            state      <= ENC_IDLE;
          end
        end
        ENC_FLUSH: begin
          if (bus.out_vld) begin
            if (bus.out_rdy) begin
              bus.out_vld <= 1'b0;
              x           <= x << SYM_WIDTH;
              nib_cnt     <= nib_cnt + NCW'(1);
              if (nib_cnt == NCW'(NIBBLES - 1)) begin
                bus.done <= 1'b1;
                state    <= ENC_DONE;
              end
            end
          end else begin
            bus.out     <= x[STATE_WIDTH-1 -: SYM_WIDTH];
            bus.out_vld <= 1'b1;
          end
        end
        ENC_DONE: begin
          bus.in_rdy <= 1'b0;
        end
        default: state <= ENC_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_encoder.sv
// Randomised scoreboard bench for ans_encoder against an arithmetic rANS model
// plus a behavioural decoder that reverses the nibble stream.
module tb_ans_encoder;
  import ans_encoder_pkg::*;

  localparam int RW = DEF_CNT_WIDTH + DEF_SYM_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  ans_encoder_if bus ();

  ans_encoder dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pmf [16] = '{8, 4, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int cmf [16] = '{8, 12, 14, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got_q[$];
  int model_x = 0;
  int model_m = 0;

  int latency  = 0;
  bit ena_rand = 1'b0;
  bit rdy_rand = 1'b0;
  int bp_left  = 0;
  int bp_after = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference rANS step: renormalise, then x = (x/f)*M + c + x%f.
  function automatic void model_encode(input int s, input bit is_last);
    int f;
    int c;
    f = pmf[s];
    c = (s == 0) ? 0 : cmf[s-1];
    while (model_x >= f * 16) begin
      exp_q.push_back(model_x % 16);
      model_x = model_x / 16;
    end
    model_x = (model_x / f) * model_m + c + (model_x % f);
    if (is_last)
      for (int i = 3; i >= 0; i--) exp_q.push_back((model_x >> (4 * i)) & 15);
  endfunction

  function automatic int table_lookup(input logic [1:0] t, input int qv);
    if (qv < 0 || qv > 15) return 0;
    if (t == READ_TYPE_CMF) return cmf[qv];
    if (t == READ_TYPE_PMF) return pmf[qv];
    return 0;
  endfunction

  // Frequency table with programmable answer latency.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.read_rdy    = 1'b0;
    bus.read_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.read_type == READ_TYPE_NONE) begin
        bus.read_rdy = 1'b0;
        wait_cnt     = 0;
      end else if (wait_cnt >= latency) begin
        bus.read_rdy    = 1'b1;
        bus.read_result = RW'(table_lookup(bus.read_type, int'(bus.read_query)));
      end else begin
        bus.read_rdy = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Clock-enable and consumer pacing, with an optional backpressure burst.
  initial begin
    ena         = 1'b0;
    bus.out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ena = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bp_left > 0 && bus.out_vld && got_q.size() >= bp_after) begin
        bus.out_rdy = 1'b0;
        bp_left--;
      end else if (rdy_rand) begin
        bus.out_rdy = ($urandom_range(0, 1) == 1);
      end else begin
        bus.out_rdy = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, held-output stability, query release.
  initial begin
    bit prev_cap;
    bit prev_hold;
    int prev_out;
    prev_cap  = 1'b0;
    prev_hold = 1'b0;
    prev_out  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cap  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_cap) checkOutput("read_type_none", int'(bus.read_type), int'(READ_TYPE_NONE));
        if (prev_hold) begin
          checkOutput("hold_out_vld", int'(bus.out_vld), 1);
          checkOutput("hold_out", int'(bus.out), prev_out);
        end
        if (bus.out_vld && bus.out_rdy && ena) begin
          got_q.push_back(int'(bus.out));
          if (exp_q.size() == 0) checkOutput("extra_nibble", int'(bus.out), -1);
          else checkOutput("nibble", int'(bus.out), exp_q.pop_front());
        end
        prev_cap  = ena && bus.read_rdy && (bus.read_type != READ_TYPE_NONE);
        prev_hold = bus.out_vld && !(bus.out_rdy && ena);
        prev_out  = int'(bus.out);
      end
    end
  end

  task automatic applyStimulus(input int syms[$]);
    bit sent;
    foreach (syms[i]) begin
      @(posedge clk);
      #1;
      bus.in      = 4'(syms[i]);
      bus.in_last = (i == syms.size() - 1);
      bus.in_vld  = 1'b1;
      sent = 1'b0;
      for (int k = 0; k < 500 && !sent; k++) begin
        @(negedge clk);
        if (bus.in_rdy && ena) begin
          model_encode(syms[i], i == syms.size() - 1);
          sent = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      bus.in_vld = 1'b0;
      if (!sent) begin
        checkOutput("input_accept", 0, 1);
        return;
      end
    end
  endtask

  task automatic run_scenario(input string name, input int syms[$], input int lat,
                              input bit er, input bit rr);
    latency  = lat;
    ena_rand = er;
    rdy_rand = rr;
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_rst_in_rdy"}, int'(bus.in_rdy), 0);
    checkOutput({name, "_rst_out_vld"}, int'(bus.out_vld), 0);
    checkOutput({name, "_rst_out"}, int'(bus.out), 0);
    checkOutput({name, "_rst_done"}, int'(bus.done), 0);
    checkOutput({name, "_rst_read_type"}, int'(bus.read_type), int'(READ_TYPE_NONE));
    checkOutput({name, "_rst_read_query"}, int'(bus.read_query), 0);
    exp_q.delete();
    got_q.delete();
    model_m = cmf[15];
    model_x = model_m;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 100 && bus.read_type == READ_TYPE_NONE; k++) @(negedge clk);
    checkOutput({name, "_init_type"}, int'(bus.read_type), int'(READ_TYPE_CMF));
    checkOutput({name, "_init_query"}, int'(bus.read_query), 15);
    for (int k = 0; k < 200 && !bus.in_rdy; k++) @(negedge clk);
    checkOutput({name, "_init_in_rdy"}, int'(bus.in_rdy), 1);
    applyStimulus(syms);
    for (int k = 0; k < 3000 && !bus.done; k++) @(negedge clk);
    checkOutput({name, "_done"}, int'(bus.done), 1);
    repeat (5) @(negedge clk);
    checkOutput({name, "_done_sticky"}, int'(bus.done), 1);
    checkOutput({name, "_done_in_rdy"}, int'(bus.in_rdy), 0);
    checkOutput({name, "_pending_expect"}, exp_q.size(), 0);
  endtask

  task automatic check_list(input string name, input int want[$]);
    checkOutput({name, "_count"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      checkOutput({name, "_list"}, got_q[i], want[i]);
  endtask

  // Independent decoder over the reversed stream; yields symbols last-first.
  task automatic round_trip(input int sent[$]);
    int rev[$];
    int x;
    int idx;
    int s;
    int slot;
    for (int i = got_q.size() - 1; i >= 0; i--) rev.push_back(got_q[i]);
    if (rev.size() < 4) begin
      checkOutput("roundtrip_len", rev.size(), 4);
      return;
    end
    x   = rev[0] | (rev[1] << 4) | (rev[2] << 8) | (rev[3] << 12);
    idx = 4;
    for (int k = sent.size() - 1; k >= 0; k--) begin
      slot = x % model_m;
      s = 0;
      while (s < 15 && cmf[s] <= slot) s++;
      x = pmf[s] * (x / model_m) + slot - ((s == 0) ? 0 : cmf[s-1]);
      while (x < model_m && idx < rev.size()) begin
        x = (x << 4) | rev[idx];
        idx++;
      end
      checkOutput("roundtrip_sym", s, sent[k]);
    end
    checkOutput("roundtrip_state", x, model_m);
    checkOutput("roundtrip_used", idx, rev.size());
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int syms[$];
    int want[$];
    rst         = 1'b1;
    bus.in      = '0;
    bus.in_last = 1'b0;
    bus.in_vld  = 1'b0;

    syms.delete();
    syms.push_back(0);
    run_scenario("sym0", syms, 0, 1'b0, 1'b0);
    want = {0, 0, 2, 0};
    check_list("sym0", want);

    syms.delete();
    syms.push_back(3);
    run_scenario("sym3", syms, 0, 1'b0, 1'b0);
    want = {0, 0, 8, 14};
    check_list("sym3", want);

    syms = {3, 3};
    want = {14, 0, 0, 4, 14};
    run_scenario("sym33", syms, 0, 1'b0, 1'b0);
    check_list("sym33", want);

    bp_after = 2;
    bp_left  = 5;
    run_scenario("backpressure", syms, 0, 1'b0, 1'b0);
    check_list("backpressure", want);
    checkOutput("bp_applied", bp_left, 0);
    bp_left = 0;

    run_scenario("latency", syms, 3, 1'b1, 1'b0);
    check_list("latency", want);

    syms.delete();
    for (int i = 0; i < 200; i++) syms.push_back(int'($urandom_range(0, 3)));
    run_scenario("random", syms, 1, 1'b1, 1'b1);
    round_trip(syms);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
